// File: rtl/alu_param_pkg.sv
// alu_param_pkg
//   Shared definitions for seq_alu_param:
//   - the operation mode encoding,
//   - the controller state enum,
//   - a two's-complement negate helper.
package alu_param_pkg;

    localparam logic [2:0] MODE_MULU = 3'd0;
    localparam logic [2:0] MODE_DIVU = 3'd1;
    localparam logic [2:0] MODE_SRL  = 3'd2;
    localparam logic [2:0] MODE_AVGU = 3'd3;
    localparam logic [2:0] MODE_MULS = 3'd4;
    localparam logic [2:0] MODE_DIVS = 3'd5;
    localparam logic [2:0] MODE_SLL  = 3'd6;
    localparam logic [2:0] MODE_SRA  = 3'd7;

    // Widest value the negate helper handles.
    // Callers zero-extend into it and truncate the result back.
    // This is exact modulo 2^n, so it covers WIDTH up to 64.
    localparam int NEG_MAX_W = 128;

    typedef enum logic [2:0] {
        IDLE,
        MUL,
        DIV,
        SHIFT,
        AVG,
        FIX,
        OUT
    } alu_state_e;

    function automatic logic [NEG_MAX_W-1:0] twos_neg(input logic [NEG_MAX_W-1:0] v);
        return ~v + NEG_MAX_W'(1);
    endfunction

endpackage

// File: rtl/alu_addsub.sv
// alu_addsub
//   N-bit adder/subtractor shared by the multiply, divide and average paths.
//   Ports:
//     a_i, b_i  operands
//     sub_i     1 selects a_i - b_i, 0 selects a_i + b_i
//     y_o       result (N bits; the top bit is the carry or borrow)
module alu_addsub #(
    parameter int N = 33
) (
    input  logic [N-1:0] a_i,
    input  logic [N-1:0] b_i,
    input  logic         sub_i,
    output logic [N-1:0] y_o
);

    assign y_o = sub_i ? (a_i - b_i) : (a_i + b_i);

endmodule

// File: rtl/seq_alu_param.sv
// seq_alu_param
//   Multi-cycle integer ALU.
//   Accepts one operation per valid pulse while idle.
//   Multiply and divide run WIDTH shift-add / shift-subtract steps.
//   Signed multiply/divide work on magnitudes and fix the sign in a FIX cycle.
//   Ports:
//     clk, rst_n  clock and asynchronous active-low reset
//     valid       request, sampled only in IDLE
//     mode        operation select
//     in_A, in_B  operands
//     ready       one-cycle result pulse
//     out         result (2*WIDTH bits), zero unless ready
//     dz          divide-by-zero flag, qualified by ready
module seq_alu_param
    import alu_param_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 valid,
    input  logic [2:0]           mode,
    input  logic [WIDTH-1:0]     in_A,
    input  logic [WIDTH-1:0]     in_B,
    output logic                 ready,
    output logic [2*WIDTH-1:0]   out,
    output logic                 dz
);

    localparam int CW = $clog2(WIDTH);
    localparam int W2 = 2 * WIDTH;

    alu_state_e       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [2:0]       mode_q, mode_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [W2-1:0]    acc_q, acc_d;
    logic             sa_q, sa_d, sb_q, sb_d, dzp_q, dzp_d;
    logic             ready_q, ready_d, dz_q, dz_d;
    logic [W2-1:0]    out_q, out_d;

    logic [WIDTH:0]   as_x, as_y, as_sum;
    logic             as_sub;
    logic             in_signed, div_take;
    logic [WIDTH-1:0] a_mag, b_mag, sh_res, fix_q, fix_r;
    logic [W2-1:0]    neg_full;
    logic [WIDTH-1:0] neg_lo, neg_hi;

    // Shared adder routing:
    //   MUL adds B to the high half.
    //   DIV subtracts B from the shifted partial remainder.
    //   AVG adds the two operands.
    assign as_sub = (state_q == DIV);
    assign as_x   = (state_q == MUL) ? {1'b0, acc_q[W2-1:WIDTH]}   :
                    (state_q == DIV) ? {1'b0, acc_q[W2-2:WIDTH-1]} : {1'b0, a_q};
    assign as_y   = {1'b0, b_q};

    alu_addsub #(.N(WIDTH + 1)) u_addsub (
        .a_i   (as_x),
        .b_i   (as_y),
        .sub_i (as_sub),
        .y_o   (as_sum)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        dzp_d   = dzp_q;
        ready_d = 1'b0;
        out_d   = '0;
        dz_d    = 1'b0;

        in_signed = (mode == MODE_MULS) || (mode == MODE_DIVS);
        a_mag     = (in_signed && in_A[WIDTH-1]) ? WIDTH'(twos_neg(NEG_MAX_W'(in_A))) : in_A;
        b_mag     = (in_signed && in_B[WIDTH-1]) ? WIDTH'(twos_neg(NEG_MAX_W'(in_B))) : in_B;

        // When the partial remainder carries out of bit 2W-1, the shifted value
        // is at least 2^W, which exceeds any divisor. The subtraction then always
        // succeeds, and its low WIDTH bits are the exact new remainder.
        div_take  = acc_q[W2-1] | ~as_sum[WIDTH];

        neg_full  = W2'(twos_neg(NEG_MAX_W'(acc_q)));
        neg_lo    = WIDTH'(twos_neg(NEG_MAX_W'(acc_q[WIDTH-1:0])));
        neg_hi    = WIDTH'(twos_neg(NEG_MAX_W'(acc_q[W2-1:WIDTH])));
        fix_q     = (sa_q ^ sb_q) ? neg_lo : acc_q[WIDTH-1:0];
        fix_r     = sa_q ? neg_hi : acc_q[W2-1:WIDTH];

        case (mode_q)
            MODE_SLL: sh_res = a_q << b_q[CW-1:0];
            MODE_SRA: sh_res = $signed(a_q) >>> b_q[CW-1:0];
            default:  sh_res = a_q >> b_q[CW-1:0];
        endcase

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (valid) begin
                    mode_d = mode;
                    sa_d   = in_signed & in_A[WIDTH-1];
                    sb_d   = in_signed & in_B[WIDTH-1];
                    a_d    = a_mag;
                    b_d    = b_mag;
                    dzp_d  = 1'b0;
                    case (mode)
                        MODE_MULU, MODE_MULS: begin
                            acc_d   = {{WIDTH{1'b0}}, a_mag};
                            state_d = MUL;
                        end
                        MODE_DIVU, MODE_DIVS: begin
                            if (in_B == '0) begin
                                acc_d   = {in_A, {WIDTH{1'b1}}};
                                dzp_d   = 1'b1;
                                state_d = OUT;
                            end else begin
                                acc_d   = {{WIDTH{1'b0}}, a_mag};
                                state_d = DIV;
                            end
                        end
                        MODE_SRL, MODE_SLL, MODE_SRA: state_d = SHIFT;
                        default:                      state_d = AVG;
                    endcase
                end
            end
            MUL: begin
                // {carry, hi, lo} >> 1 after the conditional add
                acc_d = acc_q[0] ? {as_sum, acc_q[WIDTH-1:1]} : {1'b0, acc_q[W2-1:1]};
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) state_d = mode_q[2] ? FIX : OUT;
            end
            DIV: begin
                acc_d = div_take ? {as_sum[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1}
                                 : {acc_q[W2-2:0], 1'b0};
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) state_d = mode_q[2] ? FIX : OUT;
            end
            SHIFT: begin
                acc_d   = {{WIDTH{1'b0}}, sh_res};
                state_d = OUT;
            end
            AVG: begin
                acc_d   = {{WIDTH{1'b0}}, as_sum[WIDTH:1]};
                state_d = OUT;
            end
            FIX: begin
                if (mode_q == MODE_MULS) begin
                    if (sa_q ^ sb_q) acc_d = neg_full;
                end else begin
                    acc_d = {fix_r, fix_q};
                end
                state_d = OUT;
            end
            OUT: begin
                ready_d = 1'b1;
                out_d   = acc_q;
                dz_d    = dzp_q;
                acc_d   = '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            mode_q  <= '0;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            sa_q    <= 1'b0;
            sb_q    <= 1'b0;
            dzp_q   <= 1'b0;
            ready_q <= 1'b0;
            out_q   <= '0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            dzp_q   <= dzp_d;
            ready_q <= ready_d;
            out_q   <= out_d;
            dz_q    <= dz_d;
        end
    end

    assign ready = ready_q;
    assign out   = out_q;
    assign dz    = dz_q;

endmodule

// File: tb/tb_seq_alu_param.sv
module tb_seq_alu_param;

    logic        clk;
    logic        rst_n;
    logic        valid;
    logic [2:0]  mode;
    logic [31:0] in_A, in_B;
    logic        ready;
    logic [63:0] out;
    logic        dz;

    int errors = 0;
    int checks = 0;

    seq_alu_param #(.WIDTH(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .valid (valid),
        .mode  (mode),
        .in_A  (in_A),
        .in_B  (in_B),
        .ready (ready),
        .out   (out),
        .dz    (dz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference model: plain integer arithmetic on the operation's meaning.
    function automatic void model(input logic [2:0] m, input logic [31:0] a, input logic [31:0] b,
                                  output logic [63:0] o, output logic z, output int lat);
        longint sa, sb;
        logic [31:0] q, r, t;
        logic [32:0] s;
        int sh;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        sh  = int'(b[4:0]);
        z   = 1'b0;
        o   = 64'd0;
        lat = 2;
        case (m)
            3'd0: begin
                o   = {32'd0, a} * {32'd0, b};
                lat = 33;
            end
            3'd4: begin
                o   = 64'(sa * sb);
                lat = 34;
            end
            3'd1, 3'd5: begin
                if (b == 32'd0) begin
                    o   = {a, 32'hFFFF_FFFF};
                    z   = 1'b1;
                    lat = 1;
                end else if (m == 3'd1) begin
                    q   = a / b;
                    r   = a % b;
                    o   = {r, q};
                    lat = 33;
                end else begin
                    q   = 32'(sa / sb);
                    r   = 32'(sa % sb);
                    o   = {r, q};
                    lat = 34;
                end
            end
            3'd2: o = {32'd0, a >> sh};
            3'd6: o = {32'd0, a << sh};
            3'd7: begin
                t = 32'($signed(a) >>> sh);
                o = {32'd0, t};
            end
            default: begin
                s = {1'b0, a} + {1'b0, b};
                o = {32'd0, s[32:1]};
            end
        endcase
    endfunction

    // Issue one op right after a clock edge, then wait for and check its result.
    task automatic run_op(input logic [2:0] m, input logic [31:0] a, input logic [31:0] b,
                          input string tag);
        logic [63:0] eo;
        logic        ez;
        int          el, n;
        model(m, a, b, eo, ez, el);
        valid = 1'b1; mode = m; in_A = a; in_B = b;
        @(posedge clk); #1;
        valid = 1'b1; mode = 3'($urandom); in_A = $urandom; in_B = $urandom;
        check({tag, "/busy_ready"}, {63'd0, ready}, 64'd0);
        check({tag, "/busy_out"}, out, 64'd0);
        n = 0;
        while (ready !== 1'b1 && n < 100) begin
            @(posedge clk); #1;
            valid = 1'b0;
            n++;
        end
        check({tag, "/latency"}, 64'(n), 64'(el));
        check({tag, "/out"}, out, eo);
        check({tag, "/dz"}, {63'd0, dz}, {63'd0, ez});
        valid = 1'b0;
    endtask

    initial begin
        logic [2:0]  rm;
        logic [31:0] ra, rb;
        int          n;

        rst_n = 1'b0; valid = 1'b0; mode = 3'd0; in_A = '0; in_B = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset/ready", {63'd0, ready}, 64'd0);
        check("reset/out", out, 64'd0);
        check("reset/dz", {63'd0, dz}, 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_op(3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulu_max");
        run_op(3'd4, 32'hFFFF_FFFD, 32'd7,         "muls_neg");
        run_op(3'd4, 32'h8000_0000, 32'h8000_0000, "muls_minmin");
        run_op(3'd1, 32'd100,       32'd7,         "divu_100_7");
        run_op(3'd5, 32'hFFFF_FFF9, 32'd2,         "divs_neg7_2");
        run_op(3'd5, 32'h8000_0000, 32'hFFFF_FFFF, "divs_ovf");
        run_op(3'd1, 32'd5,         32'd0,         "divu_zero");
        run_op(3'd5, 32'hFFFF_FFF0, 32'd0,         "divs_zero");
        run_op(3'd7, 32'h8000_0000, 32'd31,        "sra_31");
        run_op(3'd6, 32'd1,         32'h21,        "sll_wrap");
        run_op(3'd2, 32'hF000_000F, 32'd4,         "srl_4");
        run_op(3'd3, 32'hFFFF_FFFF, 32'd1,         "avgu_carry");
        run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFE, "divu_bigdiv");

        // Reset in the middle of a multiply, at counter = 10
        valid = 1'b1; mode = 3'd0; in_A = 32'hFFFF_FFFF; in_B = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("midrst/ready", {63'd0, ready}, 64'd0);
        check("midrst/out", out, 64'd0);
        check("midrst/dz", {63'd0, dz}, 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_op(3'd1, 32'd9, 32'd3, "divu_after_rst");

        // Reset while the result pulse is up clears it at once
        valid = 1'b1; mode = 3'd1; in_A = 32'd1; in_B = 32'd0;
        @(posedge clk); #1;
        valid = 1'b0;
        n = 0;
        while (ready !== 1'b1 && n < 10) begin
            @(posedge clk); #1;
            n++;
        end
        check("rdyrst/seen", {63'd0, ready}, 64'd1);
        rst_n = 1'b0;
        #1;
        check("rdyrst/ready", {63'd0, ready}, 64'd0);
        check("rdyrst/out", out, 64'd0);
        check("rdyrst/dz", {63'd0, dz}, 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 48; i++) begin
            rm = 3'($urandom_range(0, 7));
            ra = $urandom;
            rb = ($urandom_range(0, 9) == 0) ? 32'd0 : $urandom;
            if ($urandom_range(0, 3) == 0) rb = rb >> $urandom_range(16, 31);
            run_op(rm, ra, rb, $sformatf("rand%0d_m%0d", i, rm));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/seq_alu_param.md
# seq_alu_param

Parametrised multi-cycle integer ALU, the successor to the team's fixed 32-bit four-mode sequential ALU. It accepts one operation per valid pulse and runs multiply and divide as WIDTH-step shift-add / shift-subtract iterations. It adds signed multiply, signed divide, left and arithmetic shifts, full-range shift amounts, and a divide-by-zero flag. It sits on the core's execute stage behind the same single-cycle valid/ready pulse handshake.

## Interface
- WIDTH, 32: operand width.
  - Power of two, at least 8.
  - Result width is 2*WIDTH.
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- valid  input  1  operation request; sampled only in IDLE.
- mode  input  3  operation select, sampled with valid:
  - 0 mulu, 1 divu, 2 srl, 3 avgu
  - 4 muls, 5 divs, 6 sll, 7 sra
- in_A  input  WIDTH  operand A: multiplicand, dividend, shift source, or avg addend.
- in_B  input  WIDTH  operand B: multiplier, divisor, shift amount, or avg addend.
- ready  output  1  result-valid pulse, high for exactly one cycle; reset 0.
- out  output  2*WIDTH  result; meaningful only while ready=1, otherwise 0; reset 0.
- dz  output  1  divide-by-zero flag, qualified by ready; reset 0.

## Operation
- States: IDLE, MUL, DIV, SHIFT, AVG, FIX, OUT.
- IDLE:
  - valid=1 latches the operands (magnitudes for modes 4/5) plus the sign flags sA, sB.
  - Next state by mode: MUL, DIV, SHIFT or AVG.
  - Divide by zero (mode 1/5 with in_B=0) goes straight to OUT instead.
- MUL/DIV iterate WIDTH cycles with counter 0..WIDTH-1 ($clog2(WIDTH) bits).
  - At counter=WIDTH-1: go to FIX for modes 4/5, else to OUT.
- SHIFT, AVG and FIX each last one cycle, then OUT.
- OUT lasts one cycle, then IDLE.
- valid and mode are ignored outside IDLE; there is no abort and no queueing.
- Multiply, per step: if acc[0], then hi = hi + B with a (WIDTH+1)-bit carry; then shift {carry, hi, lo} right by 1.
- Divide, per step: trial = acc[2W-2:W-1] - B in WIDTH+1 bits.
  - trial non-negative: acc = {trial[W-1:0], acc[W-2:0], 1}.
  - trial negative: acc = acc << 1.
- Divide result layout: out = {remainder, quotient}.
- Signed fix (FIX state), applied to magnitude results:
  - muls: negate the 2W product if sA^sB.
  - divs: negate the quotient if sA^sB; negate the remainder if sA (truncating division).
- divs overflow (most-negative / -1): quotient wraps to most-negative, remainder 0, no flag.
- Divide by zero: out = {in_A, all-ones}, dz=1.
- Shifts:
  - Shift amount is in_B[$clog2(WIDTH)-1:0]; upper bits are ignored.
  - Result goes in out[W-1:0]; the upper half is 0, except sra, whose upper half is also 0 (not sign-extended into the upper half).
- avgu: out[W-1:0] = (A + B) >> 1, computed in WIDTH+1 bits so no carry is lost; the upper half is 0.

## Timing
- valid is accepted at edge t.
- ready is high in the cycle after edge:
  - t+WIDTH+1 for mulu/divu
  - t+WIDTH+2 for muls/divs
  - t+2 for shifts and avgu
  - t+1 for divide by zero
- Back-to-back: valid may be asserted in the cycle after OUT (IDLE); minimum issue interval is latency+1.
- Asynchronous reset at any point, mid-iteration included:
  - Forces IDLE, clears counter, operands and accumulator.
  - ready=0, out=0, dz=0 immediately; the in-flight operation is lost.
- During OUT, the accumulator is cleared on exit; out returns to 0 in IDLE.

## Structure
- Package alu_param_pkg holds:
  - the mode encoding constants (MODE_MULU … MODE_SRA)
  - the state enum
  - a helper function for two's-complement negate
- One sub-module is natural: alu_addsub, a WIDTH+1-bit adder/subtractor with a sub select. It is shared by MUL (add), DIV (trial subtract) and AVG (add).
- Everything else stays in seq_alu_param, with one combinational next-state/datapath block and one sequential block.

## Test plan
All cases use WIDTH=32.
- mulu 0xFFFFFFFF × 0xFFFFFFFF -> ready after 33 cycles, out=0xFFFFFFFE00000001, dz=0.
- muls -3 × 7 -> ready after 34 cycles, out=0xFFFFFFFFFFFFFFEB; muls 0x80000000 × 0x80000000 -> out=0x4000000000000000.
- divu 100 / 7 -> out={2, 14}; divs -7 / 2 -> quotient 0xFFFFFFFD, remainder 0xFFFFFFFF; divs 0x80000000 / -1 -> quotient 0x80000000, remainder 0.
- divu 5 / 0 -> ready after 1 cycle, out=0x00000005FFFFFFFF, dz=1.
- sra 0x80000000 by 31 -> out=0x00000000FFFFFFFF; sll 1 by in_B=0x21 -> out=0x2; avgu 0xFFFFFFFF, 0x1 -> out=0x80000000.
- rst_n low at counter=10 of mulu -> ready, out and dz go 0 immediately; a divu 9/3 issued after release returns {0, 3} with normal latency.
